// File: rtl/bist_pattern_session_if.sv
// -----------------------------------------------------------------------------
// bist_pattern_session_if
//
// Purpose:
//   Bundles the control, pattern and response signals of one self-test
//   session. CK and RST stay plain ports on the controller.
//
// Signals:
//   START  begin a session (sampled in IDLE and DONE)
//   EN     advance enable; 0 stalls a running session
//   ABORT  cancel the session
//   RESP   response of the device under test to the current PAT
//   PAT    current pattern (registered LFSR state)
//   SIG    current MISR signature
//   CNT    patterns captured this session
//   BUSY   session running
//   DONE   session complete
//   PASS   valid while DONE: final signature matched the golden value
//
// Modports:
//   master  drives START/EN/ABORT/RESP, observes the status outputs
//   slave   the session controller
// -----------------------------------------------------------------------------
interface bist_pattern_session_if #(
    parameter int PAT_W  = 9,
    parameter int RESP_W = 2,
    parameter int CNT_W  = 9
);
    logic              START;
    logic              EN;
    logic              ABORT;
    logic [RESP_W-1:0] RESP;
    logic [PAT_W-1:0]  PAT;
    logic [RESP_W-1:0] SIG;
    logic [CNT_W-1:0]  CNT;
    logic              BUSY;
    logic              DONE;
    logic              PASS;

    modport master (
        output START, EN, ABORT, RESP,
        input  PAT, SIG, CNT, BUSY, DONE, PASS
    );

    modport slave (
        input  START, EN, ABORT, RESP,
        output PAT, SIG, CNT, BUSY, DONE, PASS
    );
endinterface

// File: rtl/bist_pattern_session.sv
// -----------------------------------------------------------------------------
// bist_pattern_session
//
// Purpose:
//   Self-test session controller. A Galois LFSR presents patterns on PAT, the
//   DUT responses on RESP are compacted into a Galois MISR over NUM_PAT
//   captures, and the final signature is compared with GOLDEN_SIG.
//
// Ports:
//   CK   clock, rising edge
//   RST  asynchronous reset, active-high
//   bus  session interface (slave modport):
//          in  START, EN, ABORT, RESP
//          out PAT, SIG, CNT, BUSY, DONE, PASS
//
// Sessions:
//   IDLE --START--> RUN --NUM_PAT captures--> DONE --START--> RUN
//   ABORT returns RUN or DONE to IDLE (ABORT beats START and EN).
// -----------------------------------------------------------------------------
module bist_pattern_session #(
    parameter int                PAT_W      = 9,
    parameter int                RESP_W     = 2,
    parameter int                NUM_PAT    = 256,
    parameter logic [PAT_W-1:0]  LFSR_SEED  = 9'h001,
    parameter logic [PAT_W-1:0]  LFSR_TAPS  = 9'h110,
    parameter logic [RESP_W-1:0] MISR_TAPS  = 2'b11,
    parameter logic [RESP_W-1:0] GOLDEN_SIG = 2'b00,
    parameter int                CNT_W      = $clog2(NUM_PAT + 1)
) (
    input  logic                  CK,
    input  logic                  RST,
    bist_pattern_session_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PAT_W-1:0]  pat_q,   pat_d;
    logic [RESP_W-1:0] sig_q,   sig_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              pass_q,  pass_d;

    logic [PAT_W-1:0]  lfsr_step;
    logic [RESP_W-1:0] misr_step;
    logic              last_capture;

    // Next LFSR / MISR values, used only when a capture actually happens.
    always_comb begin
        lfsr_step = (pat_q >> 1) ^ (pat_q[0] ? LFSR_TAPS : '0);
        // Zero lock: an all-zero LFSR would never leave zero.
        if (lfsr_step == '0) begin
            lfsr_step = PAT_W'(1);
        end
        misr_step = ((sig_q >> 1) ^ (sig_q[0] ? MISR_TAPS : '0)) ^ bus.RESP;
    end

    // The capture taking CNT from NUM_PAT-1 to NUM_PAT ends the session.
    assign last_capture = (cnt_q == CNT_W'(NUM_PAT - 1));

    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    state_d = ST_RUN;
                    pat_d   = LFSR_SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end

            ST_RUN: begin
                // ABORT wins over EN; partial SIG/CNT are kept for inspection.
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (bus.EN) begin
                    // RESP belongs to the PAT shown this cycle, so capture and
                    // step the LFSR together.
                    pat_d = lfsr_step;
                    sig_d = misr_step;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_capture) begin
                        state_d = ST_DONE;
                        pass_d  = (misr_step == GOLDEN_SIG);
                    end
                end
            end

            ST_DONE: begin
                if (bus.ABORT) begin
                    state_d = ST_IDLE;
                    pass_d  = 1'b0;
                end else if (bus.START) begin
                    state_d = ST_RUN;
                    pat_d   = LFSR_SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
                    pass_d  = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            pat_q   <= LFSR_SEED;
            sig_q   <= '0;
            cnt_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
        end
    end

    assign bus.PAT  = pat_q;
    assign bus.SIG  = sig_q;
    assign bus.CNT  = cnt_q;
    assign bus.BUSY = (state_q == ST_RUN);
    assign bus.DONE = (state_q == ST_DONE);
    assign bus.PASS = pass_q;

endmodule

// File: tb/tb_bist_pattern_session.sv
// -----------------------------------------------------------------------------
// tb_bist_pattern_session
//
// Four controllers share one set of stimulus inputs:
//   0: NUM_PAT=4,   GOLDEN_SIG=01
//   1: NUM_PAT=4,   GOLDEN_SIG=00
//   2: NUM_PAT=256, GOLDEN_SIG=00
//   3: NUM_PAT=1,   GOLDEN_SIG=00
// A session-level model tracks captures and signature per controller; the
// expected PAT is the seed advanced CNT times.
// -----------------------------------------------------------------------------
module tb_bist_pattern_session;

    localparam int N_DUT  = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic       ck    = 1'b0;
    logic       rst   = 1'b0;
    logic       start = 1'b0;
    logic       en    = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] resp  = 2'b00;
    logic       cmp_en = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0]  act_pat  [N_DUT];
    logic [1:0]  act_sig  [N_DUT];
    logic [15:0] act_cnt  [N_DUT];
    logic        act_busy [N_DUT];
    logic        act_done [N_DUT];
    logic        act_pass [N_DUT];

    always #5 ck = ~ck;

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int         NP = (g == 2) ? 256 : ((g == 3) ? 1 : 4);
        localparam logic [1:0] GS = (g == 0) ? 2'b01 : 2'b00;
        localparam int         CW = $clog2(NP + 1);

        bist_pattern_session_if #(.PAT_W(9), .RESP_W(2), .CNT_W(CW)) bus ();

        assign bus.START = start;
        assign bus.EN    = en;
        assign bus.ABORT = abort;
        assign bus.RESP  = resp;

        bist_pattern_session #(
            .PAT_W      (9),
            .RESP_W     (2),
            .NUM_PAT    (NP),
            .LFSR_SEED  (9'h001),
            .LFSR_TAPS  (9'h110),
            .MISR_TAPS  (2'b11),
            .GOLDEN_SIG (GS),
            .CNT_W      (CW)
        ) u_dut (
            .CK  (ck),
            .RST (rst),
            .bus (bus)
        );

        assign act_pat[g]  = bus.PAT;
        assign act_sig[g]  = bus.SIG;
        assign act_cnt[g]  = 16'(bus.CNT);
        assign act_busy[g] = bus.BUSY;
        assign act_done[g] = bus.DONE;
        assign act_pass[g] = bus.PASS;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int np_of(input int i);
        return (i == 2) ? 256 : ((i == 3) ? 1 : 4);
    endfunction

    function automatic logic [1:0] gs_of(input int i);
        return (i == 0) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [8:0] lfsr_next(input logic [8:0] s);
        logic [8:0] n;
        n = (s >> 1) ^ (s[0] ? 9'h110 : 9'h000);
        if (n == 9'h000) n = 9'h001;
        return n;
    endfunction

    function automatic logic [8:0] pat_after(input int n);
        logic [8:0] s;
        s = 9'h001;
        for (int k = 0; k < n; k++) s = lfsr_next(s);
        return s;
    endfunction

    function automatic logic [1:0] misr_next(input logic [1:0] m, input logic [1:0] r);
        return ((m >> 1) ^ (m[0] ? 2'b11 : 2'b00)) ^ r;
    endfunction

    int         m_mode [N_DUT];
    int         m_cnt  [N_DUT];
    logic [1:0] m_sig  [N_DUT];
    logic       m_pass [N_DUT];

    always @(posedge ck or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_DUT; i++) begin
                m_mode[i] <= M_IDLE;
                m_cnt[i]  <= 0;
                m_sig[i]  <= 2'b00;
                m_pass[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_DUT; i++) begin
                automatic int         mode = m_mode[i];
                automatic int         cnt  = m_cnt[i];
                automatic logic [1:0] sig  = m_sig[i];
                automatic logic       pass = m_pass[i];
                automatic logic       go   = 1'b0;
                if (mode == M_RUN) begin
                    if (abort) begin
                        mode = M_IDLE;
                        pass = 1'b0;
                    end else if (en) begin
                        sig = misr_next(sig, resp);
                        cnt = cnt + 1;
                        if (cnt == np_of(i)) begin
                            mode = M_DONE;
                            pass = (sig == gs_of(i));
                        end
                    end
                end else if (mode == M_DONE && abort) begin
                    mode = M_IDLE;
                    pass = 1'b0;
                end else begin
                    go = start;
                end
                if (go) begin
                    mode = M_RUN;
                    cnt  = 0;
                    sig  = 2'b00;
                    pass = 1'b0;
                end
                m_mode[i] <= mode;
                m_cnt[i]  <= cnt;
                m_sig[i]  <= sig;
                m_pass[i] <= pass;
            end
        end
    end

    always @(negedge ck) begin
        if (cmp_en && !rst) begin
            for (int i = 0; i < N_DUT; i++) begin
                check($sformatf("pat[%0d]", i),  32'(act_pat[i]),  32'(pat_after(m_cnt[i])));
                check($sformatf("sig[%0d]", i),  32'(act_sig[i]),  32'(m_sig[i]));
                check($sformatf("cnt[%0d]", i),  32'(act_cnt[i]),  32'(m_cnt[i]));
                check($sformatf("busy[%0d]", i), 32'(act_busy[i]), 32'(m_mode[i] == M_RUN));
                check($sformatf("done[%0d]", i), 32'(act_done[i]), 32'(m_mode[i] == M_DONE));
                check($sformatf("pass[%0d]", i), 32'(act_pass[i]), 32'(m_pass[i]));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic [8:0] pat_seq [7];
    logic [1:0] sig_seq [4];

    initial begin
        pat_seq = '{9'h001, 9'h110, 9'h088, 9'h044, 9'h022, 9'h011, 9'h118};
        sig_seq = '{2'b01, 2'b10, 2'b00, 2'b01};

        #1 rst = 1'b1;
        #12 rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge ck);
        check("rst_pat",  32'(act_pat[0]),  32'h001);
        check("rst_sig",  32'(act_sig[0]),  32'h0);
        check("rst_cnt",  32'(act_cnt[0]),  32'h0);
        check("rst_busy", 32'(act_busy[0]), 32'h0);
        check("rst_done", 32'(act_done[0]), 32'h0);
        check("rst_pass", 32'(act_pass[0]), 32'h0);

        // Basic session: PAT sequence, SIG sequence, DONE/PASS timing.
        resp = 2'b01; en = 1'b1; start = 1'b1;
        @(negedge ck); start = 1'b0;
        check("seq_pat0", 32'(act_pat[2]), 32'(pat_seq[0]));
        check("run_busy", 32'(act_busy[0]), 32'h1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge ck);
            check($sformatf("seq_pat%0d", k), 32'(act_pat[2]), 32'(pat_seq[k]));
            if (k <= 4) begin
                check($sformatf("seq_sig%0d", k), 32'(act_sig[0]), 32'(sig_seq[k-1]));
                check($sformatf("seq_cnt%0d", k), 32'(act_cnt[0]), k);
            end else begin
                check("cnt_cap", 32'(act_cnt[0]), 32'd4);
            end
            if (k == 1) begin
                check("np1_done", 32'(act_done[3]), 32'h1);
                check("np1_cnt",  32'(act_cnt[3]),  32'h1);
            end
            if (k == 3) check("early_done", 32'(act_done[0]), 32'h0);
            if (k == 4) begin
                check("done_g01", 32'(act_done[0]), 32'h1);
                check("pass_g01", 32'(act_pass[0]), 32'h1);
                check("done_g00", 32'(act_done[1]), 32'h1);
                check("pass_g00", 32'(act_pass[1]), 32'h0);
            end
        end

        // Stall for three cycles mid-session.
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        @(negedge ck);
        @(negedge ck);
        check("pre_stall_sig", 32'(act_sig[0]), 32'h2);
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge ck);
            check("stall_cnt",  32'(act_cnt[0]),  32'd2);
            check("stall_sig",  32'(act_sig[0]),  32'h2);
            check("stall_pat",  32'(act_pat[0]),  32'h088);
            check("stall_busy", 32'(act_busy[0]), 32'h1);
        end
        en = 1'b1;
        @(negedge ck);
        check("stall_early_done", 32'(act_done[0]), 32'h0);
        @(negedge ck);
        check("stall_done", 32'(act_done[0]), 32'h1);
        check("stall_sig_final", 32'(act_sig[0]), 32'h1);
        check("stall_pass", 32'(act_pass[0]), 32'h1);

        // Abort at CNT=2, then restart.
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        @(negedge ck);
        @(negedge ck);
        check("abort_at_cnt", 32'(act_cnt[0]), 32'd2);
        abort = 1'b1;
        @(negedge ck); abort = 1'b0;
        check("abort_busy", 32'(act_busy[0]), 32'h0);
        check("abort_done", 32'(act_done[0]), 32'h0);
        check("abort_pass", 32'(act_pass[0]), 32'h0);
        check("abort_sig",  32'(act_sig[0]),  32'h2);
        check("abort_cnt",  32'(act_cnt[0]),  32'd2);
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        check("reload_sig",  32'(act_sig[0]),  32'h0);
        check("reload_cnt",  32'(act_cnt[0]),  32'h0);
        check("reload_pat",  32'(act_pat[0]),  32'h001);
        check("reload_busy", 32'(act_busy[0]), 32'h1);

        // Asynchronous reset between edges while running.
        @(negedge ck);
        @(negedge ck);
        #2 rst = 1'b1;
        #1;
        check("arst_pat",  32'(act_pat[0]),  32'h001);
        check("arst_sig",  32'(act_sig[0]),  32'h0);
        check("arst_cnt",  32'(act_cnt[0]),  32'h0);
        check("arst_busy", 32'(act_busy[0]), 32'h0);
        check("arst_cnt2", 32'(act_cnt[2]),  32'h0);
        #1 rst = 1'b0;
        @(negedge ck);
        check("arst_nocap_cnt",  32'(act_cnt[0]),  32'h0);
        check("arst_nocap_busy", 32'(act_busy[0]), 32'h0);

        // DONE with START+ABORT together, then identical replay.
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        repeat (4) @(negedge ck);
        check("pre_sa_done", 32'(act_done[0]), 32'h1);
        start = 1'b1; abort = 1'b1;
        @(negedge ck); start = 1'b0; abort = 1'b0;
        check("sa_done", 32'(act_done[0]), 32'h0);
        check("sa_busy", 32'(act_busy[0]), 32'h0);
        check("sa_pass", 32'(act_pass[0]), 32'h0);
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            check($sformatf("replay_pat%0d", k), 32'(act_pat[0]), 32'(pat_seq[k]));
            if (k < 4) @(negedge ck);
        end
        check("replay_done", 32'(act_done[0]), 32'h1);
        check("replay_sig",  32'(act_sig[0]),  32'h1);
        check("replay_pass", 32'(act_pass[0]), 32'h1);

        // START held high across DONE: back-to-back sessions.
        start = 1'b1;
        repeat (12) @(negedge ck);
        start = 1'b0;

        // Varied responses and stalls through a full 256-pattern session.
        abort = 1'b1;
        @(negedge ck); abort = 1'b0;
        start = 1'b1;
        @(negedge ck); start = 1'b0;
        for (int c = 0; c < 600 && !act_done[2]; c++) begin
            resp  = 2'(c ^ (c >> 3));
            en    = (c % 7) != 3;
            start = (c % 20) == 0;
            @(negedge ck);
        end
        start = 1'b0;
        check("long_done", 32'(act_done[2]), 32'h1);
        check("long_cnt",  32'(act_cnt[2]),  32'd256);
        @(negedge ck);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
